// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: owns the PC, issues single outstanding word reads and
// hands each fetched instruction to decode; execute redirects squash the path.
module instr_fetch_unit #(
    parameter int          XLEN        = 32,
    parameter int          OPCODE_SIZE = 7,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [XLEN-1:0]        imem_addr,
    input  logic                   imem_rvalid,
    input  logic [XLEN-1:0]        imem_rdata,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [XLEN-1:0]        instr,
    output logic [XLEN-1:0]        instr_pc,
    output logic [OPCODE_SIZE-1:0] opcode,
    input  logic                   redirect,
    input  logic [XLEN-1:0]        redirect_target,
    output logic                   fetch_fault,
    output logic [2:0]             state_dbg
);

    // Handshake: a transfer to decode happens on a rising edge where
    // instr_valid & instr_ready are both high and redirect is low; while
    // instr_valid is high, instr/instr_pc/opcode stay stable until that transfer.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] instr_q, instr_n;
    logic [XLEN-1:0] instr_pc_q, instr_pc_n;
    logic            fault_q, fault_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= XLEN'(RESET_PC);
            instr_q    <= XLEN'(NOP_INSTR);
            instr_pc_q <= XLEN'(RESET_PC);
            fault_q    <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            instr_q    <= instr_n;
            instr_pc_q <= instr_pc_n;
            fault_q    <= fault_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        instr_n    = instr_q;
        instr_pc_n = instr_pc_q;
        fault_n    = fault_q;

        if (redirect && state != S_FAULT) begin
            pc_n = redirect_target;
            // Leaving HOLD always squashes the held word, so park NOP again.
            instr_n = XLEN'(NOP_INSTR);
            if (redirect_target[1:0] != 2'b00) begin
                fault_n = 1'b1;
                state_n = S_FAULT;
            end else begin
                case (state)
                    S_FETCH: state_n = S_DRAIN;
                    S_WAIT:  state_n = imem_rvalid ? S_FETCH : S_DRAIN;
                    S_DRAIN: state_n = imem_rvalid ? S_FETCH : S_DRAIN;
                    default: state_n = S_FETCH;
                endcase
            end
        end else begin
            case (state)
                S_IDLE:  state_n = S_FETCH;
                S_FETCH: state_n = S_WAIT;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        instr_n    = imem_rdata;
                        instr_pc_n = pc;
                        pc_n       = pc + XLEN'(4);
                        state_n    = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        instr_n = XLEN'(NOP_INSTR);
                        state_n = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) state_n = S_FETCH;
                end
                default: state_n = S_FAULT;
            endcase
        end
    end

    assign imem_req    = (state == S_FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == S_HOLD);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign opcode      = instr_q[OPCODE_SIZE-1:0];
    assign fetch_fault = fault_q;
    assign state_dbg   = state;

endmodule
